cpu_dbus_bridge: RTL and testbench

Bridges the CPU core's single-cycle data port (`o_addr_d`, `o_rd_d`, `o_wr_d`, `o_data_wr_d`, `i_data_rd_d`) to a memory or bus slave with variable latency and a request/acknowledge handshake. It sits directly downstream of `cpu`: it consumes the core's data-port outputs, feeds `i_data_rd_d` back, and drives the core's `i_clk_ce` low to freeze the pipeline until each access completes. It replaces the zero-wait-state data memory model for real SRAM or bus targets.

---
 rtl/cpu_dbus_bridge.sv | 198 +++++++++++++++++++
 tb/tb_cpu_dbus_bridge.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dbus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_dbus_bridge                                            |
// | Description : Adapts the CPU core's single-cycle data port to a memory   |
// |               or bus slave with variable latency and a req/ack + rvalid  |
// |               handshake. The CPU is frozen through o_clk_ce until each   |
// |               access has completed.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   TIMEOUT_CYCLES : cycles spent in REQ+RESP before an access is aborted  |
// |                    (only meaningful with CPU_DBUS_TIMEOUT_EN defined)    |
// | Ports                                                                    |
// |   i_clk, i_rst_n        : clock (rising edge), async active-low reset    |
// |   i_addr_d, i_rd_d,     : CPU data-port request (address, read strobe,   |
// |   i_wr_d, i_data_wr_d   :   byte write enables, write data)              |
// |   o_data_rd_d           : read data returned to the CPU                  |
// |   o_clk_ce              : CPU clock enable, low = stall                  |
// |   o_mem_req/i_mem_ack   : memory request handshake                       |
// |   o_mem_we/be/addr/wdata: memory request attributes (word address)       |
// |   i_mem_rvalid/rdata    : memory read response                           |
// |   o_bus_err             : one-cycle pulse on a timeout abort             |
// | Configuration macro                                                      |
// |   CPU_DBUS_TIMEOUT_EN : builds the access timeout counter; when left     |
// |                         undefined the bridge waits indefinitely and      |
// |                         o_bus_err is tied low.                           |
// +--------------------------------------------------------------------------+
module cpu_dbus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_addr_d,
   input  logic        i_rd_d,
   input  logic [3:0]  i_wr_d,
   input  logic [31:0] i_data_wr_d,
   output logic [31:0] o_data_rd_d,
   output logic        o_clk_ce,
   output logic        o_mem_req,
   input  logic        i_mem_ack,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_bus_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q,    be_d;
   logic        we_q,    we_d;
   logic [31:0] rdata_q, rdata_d;

   logic is_write;
   logic request;
   logic complete;
   logic timeout;

   // A write strobe takes priority: a simultaneous read strobe is dropped.
   assign is_write = |i_wr_d;
   assign request  = i_rd_d | is_write;

   // An access completes on a write ack, a read ack with same-cycle data,
   // or read data arriving while waiting in RESP.
   always_comb begin
      complete = 1'b0;
      case (state_q)
         ST_REQ:  complete = i_mem_ack & (we_q | i_mem_rvalid);
         ST_RESP: complete = i_mem_rvalid;
         default: complete = 1'b0;
      endcase
   end

`ifdef CPU_DBUS_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Held at zero outside the access so it starts from 0 on entering REQ.
   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_REQ) || (state_q == ST_RESP)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Completion on the limit cycle wins over the abort.
   assign timeout = ((state_q == ST_REQ) || (state_q == ST_RESP)) &&
                    (cnt_q == CNT_LIMIT) && !complete;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (request) begin
               addr_d  = {i_addr_d[31:2], 2'b00};
               wdata_d = i_data_wr_d;
               be_d    = is_write ? i_wr_d : 4'hF;
               we_d    = is_write;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (timeout) begin
               rdata_d = '0;
               state_d = ST_DONE;
            end else if (i_mem_ack) begin
               if (we_q) begin
                  state_d = ST_DONE;
               end else if (i_mem_rvalid) begin
                  rdata_d = i_mem_rdata;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (timeout) begin
               rdata_d = '0;
               state_d = ST_DONE;
            end else if (i_mem_rvalid) begin
               rdata_d = i_mem_rdata;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // The CPU consumes the word this cycle; it must not linger.
            rdata_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   // The request follows the state register, so the async reset removes it
   // immediately. Clock enable is gated by reset so the CPU stays frozen.
   assign o_mem_req   = (state_q == ST_REQ);
   assign o_clk_ce    = i_rst_n & (((state_q == ST_IDLE) & ~request) | (state_q == ST_DONE));
   assign o_mem_we    = we_q;
   assign o_mem_be    = be_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_data_rd_d = rdata_q;
   assign o_bus_err   = timeout;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^i_addr_d[1:0];

endmodule
`default_nettype wire

// File: tb/tb_cpu_dbus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_dbus_bridge                                         |
// | Description : Self-checking bench for cpu_dbus_bridge using a table of   |
// |               directed accesses plus hand-written corner sequences.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cpu_dbus_bridge;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_addr_d;
   logic        i_rd_d;
   logic [3:0]  i_wr_d;
   logic [31:0] i_data_wr_d;
   logic [31:0] o_data_rd_d;
   logic        o_clk_ce;
   logic        o_mem_req;
   logic        i_mem_ack;
   logic        o_mem_we;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cpu_dbus_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_addr_d     (i_addr_d),
      .i_rd_d       (i_rd_d),
      .i_wr_d       (i_wr_d),
      .i_data_wr_d  (i_data_wr_d),
      .o_data_rd_d  (o_data_rd_d),
      .o_clk_ce     (o_clk_ce),
      .o_mem_req    (o_mem_req),
      .i_mem_ack    (i_mem_ack),
      .o_mem_we     (o_mem_we),
      .o_mem_be     (o_mem_be),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_bus_err    (o_bus_err)
   );

   typedef struct {
      logic        rd;
      logic [3:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_dly;    // REQ cycles before ack
      int          rv_dly;     // cycles from ack to rvalid
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic        exp_we;
      int          exp_stall;  // cycles with o_clk_ce low
      logic [31:0] exp_rd;     // o_data_rd_d in DONE
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One CPU access from its first IDLE cycle (t=0) through DONE.
   task automatic run_access(input vec_t v);
      int   ack_t;
      int   rv_t;
      int   stall;
      logic done;
      ack_t = 1 + v.ack_dly;
      rv_t  = ack_t + v.rv_dly;
      stall = 0;
      done  = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(posedge clk); #1;
         i_rd_d       = v.rd;
         i_wr_d       = v.wr;
         i_addr_d     = v.addr;
         i_data_wr_d  = v.wdata;
         i_mem_rdata  = v.rdata;
         i_mem_ack    = (t == ack_t);
         i_mem_rvalid = (t == rv_t);
         #1;
         if (t == 0) check("rd_clear_before_access", o_data_rd_d, 32'h0);
         check("bus_err_quiet", o_bus_err, 1'b0);
         if (o_clk_ce) begin
            done = 1'b1;
            check("done_rdata", o_data_rd_d, v.exp_rd);
            check("stall_cycles", stall, v.exp_stall);
            check("req_low_in_done", o_mem_req, 1'b0);
         end else begin
            stall++;
            check("mem_req", o_mem_req, (t >= 1) && (t <= ack_t));
            if (o_mem_req) begin
               check("mem_addr", o_mem_addr, v.exp_addr);
               check("mem_be", o_mem_be, v.exp_be);
               check("mem_we", o_mem_we, v.exp_we);
               check("mem_wdata", o_mem_wdata, v.wdata);
            end
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL access_done: no DONE within budget, addr 0x%08h", v.addr);
      end
      i_mem_ack    = 1'b0;
      i_mem_rvalid = 1'b0;
   endtask

   // Start a read and pull reset asynchronously at cycle at_t (1=REQ, 2=RESP).
   task automatic reset_mid(input int at_t);
      for (int t = 0; t <= at_t; t++) begin
         @(posedge clk); #1;
         i_rd_d       = 1'b1;
         i_wr_d       = 4'h0;
         i_addr_d     = 32'h0000_0080;
         i_mem_ack    = (t == 1);
         i_mem_rvalid = 1'b0;
         #1;
      end
      check("req_before_reset", o_mem_req, (at_t == 1));
      check("ce_before_reset", o_clk_ce, 1'b0);
      i_mem_ack = 1'b0;
      i_rst_n   = 1'b0;
      #1;
      check("req_async_reset", o_mem_req, 1'b0);
      check("ce_async_reset", o_clk_ce, 1'b0);
      // A late response arriving during reset must be dropped.
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hFFFF_0000;
      @(posedge clk); #1;
      i_mem_rvalid = 1'b0;
      i_rd_d       = 1'b0;
      check("rd_after_reset", o_data_rd_d, 32'h0);
      i_rst_n = 1'b1;
      #1;
      check("ce_after_release", o_clk_ce, 1'b1);
      check("req_after_release", o_mem_req, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rd:1'b1, wr:4'h0, addr:32'h0000_1006, wdata:32'h0, ack_dly:0, rv_dly:0,
                  rdata:32'hDEAD_BEEF, exp_addr:32'h0000_1004, exp_be:4'hF, exp_we:1'b0,
                  exp_stall:2, exp_rd:32'hDEAD_BEEF};
      vecs[1] = '{rd:1'b0, wr:4'b0100, addr:32'h0000_0020, wdata:32'h00AB_0000, ack_dly:3, rv_dly:0,
                  rdata:32'h9999_9999, exp_addr:32'h0000_0020, exp_be:4'b0100, exp_we:1'b1,
                  exp_stall:5, exp_rd:32'h0};
      vecs[2] = '{rd:1'b1, wr:4'h0, addr:32'h0000_3000, wdata:32'h0, ack_dly:1, rv_dly:4,
                  rdata:32'h1234_5678, exp_addr:32'h0000_3000, exp_be:4'hF, exp_we:1'b0,
                  exp_stall:7, exp_rd:32'h1234_5678};
      vecs[3] = '{rd:1'b1, wr:4'hF, addr:32'h0000_0044, wdata:32'hCAFE_F00D, ack_dly:0, rv_dly:0,
                  rdata:32'h7777_7777, exp_addr:32'h0000_0044, exp_be:4'hF, exp_we:1'b1,
                  exp_stall:2, exp_rd:32'h0};
      vecs[4] = '{rd:1'b1, wr:4'h0, addr:32'hFFFF_FFFF, wdata:32'h0, ack_dly:2, rv_dly:0,
                  rdata:32'hA5A5_A5A5, exp_addr:32'hFFFF_FFFC, exp_be:4'hF, exp_we:1'b0,
                  exp_stall:4, exp_rd:32'hA5A5_A5A5};
      vecs[5] = '{rd:1'b0, wr:4'b0011, addr:32'h0000_0007, wdata:32'h0000_BEEF, ack_dly:0, rv_dly:0,
                  rdata:32'h0, exp_addr:32'h0000_0004, exp_be:4'b0011, exp_we:1'b1,
                  exp_stall:2, exp_rd:32'h0};
      vecs[6] = '{rd:1'b1, wr:4'h0, addr:32'h0000_0002, wdata:32'h0, ack_dly:0, rv_dly:1,
                  rdata:32'h0BAD_F00D, exp_addr:32'h0000_0000, exp_be:4'hF, exp_we:1'b0,
                  exp_stall:3, exp_rd:32'h0BAD_F00D};

      // Reset with a request already pending: everything quiet, CPU frozen.
      i_rst_n      = 1'b0;
      i_rd_d       = 1'b1;
      i_wr_d       = 4'h0;
      i_addr_d     = 32'h0000_1234;
      i_data_wr_d  = 32'h5555_5555;
      i_mem_ack    = 1'b1;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h1111_1111;
      repeat (3) @(posedge clk);
      #1;
      check("rst_clk_ce", o_clk_ce, 1'b0);
      check("rst_mem_req", o_mem_req, 1'b0);
      check("rst_mem_we", o_mem_we, 1'b0);
      check("rst_mem_be", o_mem_be, 4'h0);
      check("rst_mem_addr", o_mem_addr, 32'h0);
      check("rst_mem_wdata", o_mem_wdata, 32'h0);
      check("rst_rdata", o_data_rd_d, 32'h0);
      check("rst_bus_err", o_bus_err, 1'b0);
      i_rd_d       = 1'b0;
      i_mem_ack    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_rst_n      = 1'b1;
      #1;
      check("idle_clk_ce", o_clk_ce, 1'b1);

      // Table: applied back-to-back, each new request in the cycle after DONE.
      for (int i = 0; i < 7; i++) begin
         run_access(vecs[i]);
      end

      // Spurious ack/rvalid while idle must be ignored.
      @(posedge clk); #1;
      i_rd_d       = 1'b0;
      i_wr_d       = 4'h0;
      i_mem_ack    = 1'b1;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h5555_AAAA;
      #1;
      check("idle_rd_cleared", o_data_rd_d, 32'h0);
      check("idle_ce_spurious", o_clk_ce, 1'b1);
      @(posedge clk); #1;
      i_mem_ack    = 1'b0;
      i_mem_rvalid = 1'b0;
      #1;
      check("spurious_rvalid_dropped", o_data_rd_d, 32'h0);
      check("spurious_ack_no_req", o_mem_req, 1'b0);
      check("spurious_ce", o_clk_ce, 1'b1);

      // Asynchronous reset in REQ and in RESP, each followed by a clean read.
      reset_mid(1);
      run_access(vecs[0]);
      reset_mid(2);
      run_access(vecs[6]);

`ifdef CPU_DBUS_TIMEOUT_EN
      // Read never acked: error on the 8th REQ cycle, then DONE with zero data.
      for (int t = 0; t <= 9; t++) begin
         @(posedge clk); #1;
         i_rd_d       = 1'b1;
         i_wr_d       = 4'h0;
         i_addr_d     = 32'h0000_0100;
         i_mem_ack    = 1'b0;
         i_mem_rvalid = 1'b0;
         #1;
         if (t >= 1 && t <= 8) begin
            check("to_bus_err", o_bus_err, (t == 8));
            check("to_req_held", o_mem_req, 1'b1);
            check("to_stall", o_clk_ce, 1'b0);
         end
         if (t == 9) begin
            check("to_done_ce", o_clk_ce, 1'b1);
            check("to_done_rdata", o_data_rd_d, 32'h0);
            check("to_done_err_cleared", o_bus_err, 1'b0);
            check("to_done_req", o_mem_req, 1'b0);
         end
      end
      // Write acked exactly on the limit cycle completes without error.
      run_access('{rd:1'b0, wr:4'hF, addr:32'h0000_0200, wdata:32'h0F0F_0F0F, ack_dly:7, rv_dly:0,
                   rdata:32'h0, exp_addr:32'h0000_0200, exp_be:4'hF, exp_we:1'b1,
                   exp_stall:9, exp_rd:32'h0});
      run_access(vecs[0]);
`else
      // Without the timeout the bridge waits for as long as the slave needs.
      for (int t = 0; t <= 22; t++) begin
         @(posedge clk); #1;
         i_rd_d       = 1'b1;
         i_wr_d       = 4'h0;
         i_addr_d     = 32'h0000_0100;
         i_mem_ack    = (t == 21);
         i_mem_rvalid = (t == 21);
         i_mem_rdata  = 32'hC001_D00D;
         #1;
         if (t == 20) begin
            check("wait_req_held", o_mem_req, 1'b1);
            check("wait_stall", o_clk_ce, 1'b0);
            check("wait_no_err", o_bus_err, 1'b0);
         end
         if (t == 22) begin
            check("wait_done_ce", o_clk_ce, 1'b1);
            check("wait_done_rdata", o_data_rd_d, 32'hC001_D00D);
         end
      end
`endif

      @(posedge clk); #1;
      i_rd_d = 1'b0;
      i_wr_d = 4'h0;
      #1;
      check("final_idle_ce", o_clk_ce, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
